// File: rtl/uart_rx_cmd_fifo.sv
// Receive-side byte FIFO feeding command_decoder; bytes pop under a two-state pacing FSM (optional echo: UART_RX_ECHO_EN).
// Latency: rx_done to rx_trigger is 1 cycle; drain rate is one byte per 2 clocks.
// Backpressure: a byte arriving into a full FIFO without a same-cycle pop is dropped and flagged on rx_overflow; echo build stalls pops while tx_full.
module uart_rx_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       tx_full,
  output logic [7:0] rx_fifo_popdata,
  output logic       rx_trigger,
  output logic       tx_push,
  output logic [7:0] tx_push_data,
  output logic       rx_fifo_empty,
  output logic       rx_fifo_full,
  output logic       rx_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_popdata;
  logic          r_trigger;
  logic          r_overflow;

  logic w_pop_ok;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign rx_fifo_empty = (r_cnt == '0);
  assign rx_fifo_full  = (r_cnt == CNT_FULL);

`ifdef UART_RX_ECHO_EN
  assign w_pop_ok = (r_state == ST_IDLE) && !rx_fifo_empty && !tx_full;
`else
  assign w_pop_ok = (r_state == ST_IDLE) && !rx_fifo_empty;
`endif

  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign w_push = rx_done && (!rx_fifo_full || w_pop);
  assign w_drop = rx_done && rx_fifo_full && !w_pop;

  // Pacing FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and pop decision: pop only from IDLE, then spend one cycle in ISSUE.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pop_ok) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Storage array; contents are don't-care after reset since cnt gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rx_data;
  end

  // Pointers and occupancy; simultaneous push and pop leaves cnt unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Registered pop outputs: data held until the next pop, strobes last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_popdata  <= 8'h00;
      r_trigger  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_trigger  <= w_pop;
      r_overflow <= w_drop;
      if (w_pop) r_popdata <= r_mem[r_rptr];
    end
  end

  assign rx_fifo_popdata = r_popdata;
  assign rx_trigger      = r_trigger;
  assign rx_overflow     = r_overflow;

`ifdef UART_RX_ECHO_EN
  logic       r_tx_push;
  logic [7:0] r_tx_data;

  // Echo path mirrors every pop to the transmit FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_push <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_tx_push <= w_pop;
      if (w_pop) r_tx_data <= r_mem[r_rptr];
    end
  end

  assign tx_push      = r_tx_push;
  assign tx_push_data = r_tx_data;
`else
  logic w_unused_tx_full;
  assign w_unused_tx_full = tx_full;
  assign tx_push          = 1'b0;
  assign tx_push_data     = 8'h00;
`endif

endmodule

// File: doc/uart_rx_cmd_fifo.md
# uart_rx_cmd_fifo

- Receive-side buffer between the UART byte receiver and `command_decoder`.
- Captures each received byte into a small circular FIFO.
- Pops bytes under a two-state pacing FSM and presents each as `rx_fifo_popdata` qualified by a one-cycle `rx_trigger` pulse.
- Optionally mirrors every popped byte to the UART transmit path as an echo.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `AW`, default $clog2(DEPTH): pointer width; local, not overridable.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_done`  in  1  one-cycle strobe from the receiver; `rx_data` is valid in that cycle.
- `rx_data`  in  8  received byte.
- `tx_full`  in  1  transmit FIFO full; used only when `UART_RX_ECHO_EN` is defined.
- `rx_fifo_popdata`  out  8  last popped byte; held until the next pop.
- `rx_trigger`  out  1  one-cycle pulse marking a new `rx_fifo_popdata`.
- `tx_push`  out  1  echo push strobe.
- `tx_push_data`  out  8  echo byte.
- `rx_fifo_empty`  out  1  FIFO holds 0 entries.
- `rx_fifo_full`  out  1  FIFO holds DEPTH entries.
- `rx_overflow`  out  1  one-cycle pulse when an incoming byte is dropped.

## Operation
- Storage:
  - DEPTH x 8 register array.
  - Write pointer `wptr` and read pointer `rptr`, each AW bits, wrap modulo DEPTH.
  - Occupancy counter `cnt`, AW+1 bits, range 0..DEPTH.
- Push:
  - On `rx_done` with `cnt < DEPTH`: write `mem[wptr]`, increment `wptr`.
  - On `rx_done` with `cnt == DEPTH` and no pop this cycle: byte dropped, `rx_overflow` = 1 next cycle, pointers unchanged.
- Pop eligibility (`pop_ok`): FSM in IDLE, `cnt != 0`, and, with echo enabled, `tx_full == 0`.
- Pop:
  - `rx_fifo_popdata <= mem[rptr]`, increment `rptr`.
  - Registered outputs go high for exactly one cycle: `rx_trigger`, plus `tx_push` when echo is enabled.
- Simultaneous push and pop:
  - Both take effect.
  - `cnt` is unchanged.
  - A push into a full FIFO is accepted if a pop happens in the same cycle (no overflow).
  - A push into an empty FIFO is not visible to the pop decision until the next cycle; no write-through bypass.
- FSM states:
  - IDLE: if `pop_ok`, pop and go to ISSUE; else stay in IDLE.
  - ISSUE: `rx_trigger` high; unconditionally return to IDLE.
  - Consequence: no two consecutive `rx_trigger` cycles. `command_decoder` samples `rx_fifo_popdata` while `rx_trigger` is high.
- `rx_fifo_empty` and `rx_fifo_full` are combinational from `cnt`.
- Reset (async, any state, mid-burst included):
  - FSM to IDLE; `wptr` = `rptr` = `cnt` = 0.
  - `rx_fifo_popdata` = 0x00, `rx_trigger` = 0, `tx_push` = 0, `tx_push_data` = 0x00, `rx_overflow` = 0.
  - `rx_fifo_empty` = 1, `rx_fifo_full` = 0.
  - Buffered bytes are discarded. Array contents need not be cleared.

## Timing
- `rx_done` sampled at edge N:
  - `cnt` = 1 after edge N.
  - Pop at edge N+1; `rx_trigger` and `rx_fifo_popdata` valid after edge N+1.
  - `rx_trigger` low after edge N+2.
  - Latency from `rx_done` to `rx_trigger` is 1 cycle.
- Back-to-back buffered bytes produce `rx_trigger` every 2nd cycle; drain throughput is 1 byte per 2 clocks.
- `rx_overflow` asserts the cycle after the dropped `rx_done`.
- With echo enabled, `tx_push` is coincident with `rx_trigger`, and `tx_push_data` equals `rx_fifo_popdata`.
- `tx_full` is sampled in IDLE only; a stall holds the FSM in IDLE and pops nothing.

## Configuration
- `UART_RX_ECHO_EN` defined:
  - `tx_full` gates `pop_ok`.
  - `tx_push` and `tx_push_data` mirror each pop.
- `UART_RX_ECHO_EN` undefined:
  - `tx_full` is ignored.
  - `tx_push` is tied to 0 and `tx_push_data` to 0x00.
  - Pop depends only on FSM state and `cnt`.
  - Ports remain present in both builds.

## Test plan
- Single byte:
  - Stimulus: `rx_done` with 0x72 ('r') at edge 10.
  - Response: `rx_trigger` = 1 only in the cycle after edge 11, with `rx_fifo_popdata` = 0x72. `rx_fifo_empty` = 1 after edge 11.
- Burst:
  - Stimulus: 4 bytes 0x63, 0x53, 0x4D, 0x48 on consecutive cycles, DEPTH = 4.
  - Response: four `rx_trigger` pulses 2 cycles apart, in order. No overflow.
- Overflow:
  - Stimulus: hold `tx_full` = 1 (echo build) and push 5 bytes 0x01..0x05.
  - Response: `rx_fifo_full` = 1 after the 4th push. `rx_overflow` pulses once for 0x05. Releasing `tx_full` yields exactly 0x01..0x04.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, `rx_done` (0xAA) in the same cycle as a pop.
  - Response: no overflow, `cnt` stays 4, and 0xAA is the last byte drained.
- Reset mid-burst:
  - Stimulus: assert `rst` with 3 bytes buffered while in ISSUE.
  - Response: all outputs take their reset values immediately. No `rx_trigger` after release until a new `rx_done`.
- Non-echo build:
  - Stimulus: `tx_full` = 1 with 0x6E pushed.
  - Response: `rx_trigger` fires normally; `tx_push` stays 0.
